// File: rtl/axis_pack_pkg.sv
// Shared widths, the packed output word and the tkeep lookup for the byte packer.
package axis_pack_pkg;

  localparam int unsigned IN_W   = 8;
  localparam int unsigned OUT_W  = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned CNT_W  = $clog2(LANES);
  localparam int unsigned ASM_W  = OUT_W - IN_W;
  localparam int unsigned STAT_W = 32;

  typedef struct packed {
    logic [OUT_W-1:0] data;
    logic [LANES-1:0] keep;
    logic             last;
  } word_t;

  // cnt is the lane index of the word's final byte, so cnt=0 means one byte
  function automatic logic [LANES-1:0] keep_from_cnt(input logic [CNT_W-1:0] cnt);
    logic [LANES-1:0] keep;
    unique case (cnt)
      2'd0:    keep = 4'b0001;
      2'd1:    keep = 4'b0011;
      2'd2:    keep = 4'b0111;
      default: keep = 4'b1111;
    endcase
    return keep;
  endfunction

endpackage

// File: rtl/axis_pack_hold.sv
// Output register plus a single-word hold slot; absorbs one completed word while
// the sink stalls so the producer side never sees a combinational ready path.
module axis_pack_hold
  import axis_pack_pkg::*;
(
  input  logic  clk,
  input  logic  rstn,
  input  word_t word_i,
  input  logic  word_valid_i,
  input  logic  out_ready_i,
  output logic  out_valid_o,
  output word_t out_word_o,
  output logic  hold_valid_o
);

  logic  out_valid_q, out_valid_d;
  word_t out_word_q,  out_word_d;
  logic  hold_valid_q, hold_valid_d;
  word_t hold_word_q, hold_word_d;
  logic  out_free_c;

  // The producer is gated by ~hold_valid_q, so a new word never arrives while hold is full.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_word_d   = out_word_q;
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    out_free_c   = ~out_valid_q | out_ready_i;

    if (out_free_c) begin
      if (hold_valid_q) begin
        out_word_d   = hold_word_q;
        out_valid_d  = 1'b1;
        hold_valid_d = 1'b0;
      end else if (word_valid_i) begin
        out_word_d  = word_i;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (word_valid_i) begin
      hold_word_d  = word_i;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_q  <= 1'b0;
      out_word_q   <= '0;
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_word_q   <= out_word_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_word_o   = out_word_q;
  assign hold_valid_o = hold_valid_q;

endmodule

// File: rtl/axis_byte_packer.sv
// Packs a byte AXI-stream little-endian into 32-bit words, preserving tlast and
// marking partial final words with tkeep. Optional stats via AXIS_PACKER_STAT_EN.
module axis_byte_packer
  import axis_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  output logic              i_tready,
  input  logic              i_tvalid,
  input  logic [IN_W-1:0]   i_tdata,
  input  logic              i_tlast,
  input  logic              o_tready,
  output logic              o_tvalid,
  output logic [OUT_W-1:0]  o_tdata,
  output logic              o_tlast,
  output logic [LANES-1:0]  o_tkeep
`ifdef AXIS_PACKER_STAT_EN
  ,
  output logic [STAT_W-1:0] o_pkt_len,
  output logic [STAT_W-1:0] o_pkt_cnt
`endif
);

  logic [ASM_W-1:0] asm_data_q, asm_data_d;
  logic [CNT_W-1:0] asm_cnt_q,  asm_cnt_d;
  logic             accept_c;
  logic             word_valid_c;
  word_t            word_c;
  logic [OUT_W-1:0] lanes_c;
  logic [LANES-1:0] keep_c;
  logic             hold_valid;
  word_t            out_word;

  // Ready is the inverse of the hold flop only; o_tready never reaches it combinationally.
  assign i_tready = ~hold_valid;
  assign accept_c = i_tvalid & i_tready;

  // Assembly: drop the byte into lane asm_cnt and emit when full or at tlast.
  always_comb begin
    asm_data_d   = asm_data_q;
    asm_cnt_d    = asm_cnt_q;
    word_valid_c = 1'b0;
    word_c       = '0;
    lanes_c      = {IN_W'(0), asm_data_q};
    lanes_c[int'(asm_cnt_q)*IN_W +: IN_W] = i_tdata;
    keep_c       = keep_from_cnt(asm_cnt_q);
    for (int k = 0; k < LANES; k++) begin
      if (!keep_c[k]) lanes_c[k*IN_W +: IN_W] = '0;
    end

    if (accept_c) begin
      if (asm_cnt_q == CNT_W'(LANES-1) || i_tlast) begin
        word_valid_c = 1'b1;
        word_c.data  = lanes_c;
        word_c.keep  = keep_c;
        word_c.last  = i_tlast;
        asm_cnt_d    = '0;
        asm_data_d   = '0;
      end else begin
        asm_data_d = lanes_c[ASM_W-1:0];
        asm_cnt_d  = asm_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      asm_data_q <= '0;
      asm_cnt_q  <= '0;
    end else begin
      asm_data_q <= asm_data_d;
      asm_cnt_q  <= asm_cnt_d;
    end
  end

  axis_pack_hold u_hold (
    .clk          (clk),
    .rstn         (rstn),
    .word_i       (word_c),
    .word_valid_i (word_valid_c),
    .out_ready_i  (o_tready),
    .out_valid_o  (o_tvalid),
    .out_word_o   (out_word),
    .hold_valid_o (hold_valid)
  );

  assign o_tdata = out_word.data;
  assign o_tkeep = out_word.keep;
  assign o_tlast = out_word.last;

`ifdef AXIS_PACKER_STAT_EN
  logic [STAT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [STAT_W-1:0] pkt_len_q,  pkt_len_d;
  logic [STAT_W-1:0] pkt_cnt_q,  pkt_cnt_d;

  // Running byte count restarts at each tlast; both stats wrap naturally.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pkt_len_d  = pkt_len_q;
    pkt_cnt_d  = pkt_cnt_q;
    if (accept_c) begin
      if (i_tlast) begin
        pkt_len_d  = byte_cnt_q + STAT_W'(1);
        pkt_cnt_d  = pkt_cnt_q + STAT_W'(1);
        byte_cnt_d = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byte_cnt_q <= '0;
      pkt_len_q  <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      byte_cnt_q <= byte_cnt_d;
      pkt_len_q  <= pkt_len_d;
      pkt_cnt_q  <= pkt_cnt_d;
    end
  end

  assign o_pkt_len = pkt_len_q;
  assign o_pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_axis_byte_packer.sv
// Self-checking bench for axis_byte_packer: byte packets in, packed words checked
// against a packet-level model; also covers stalls, reset and optional stats.
module tb_axis_byte_packer;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } tw_t;
  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rstn;
  logic        i_tready;
  logic        i_tvalid;
  logic [7:0]  i_tdata;
  logic        i_tlast;
  logic        o_tready;
  logic        o_tvalid;
  logic [31:0] o_tdata;
  logic        o_tlast;
  logic [3:0]  o_tkeep;
`ifdef AXIS_PACKER_STAT_EN
  logic [31:0] o_pkt_len;
  logic [31:0] o_pkt_cnt;
`endif

  tw_t exp_q[$];
  tw_t rx_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  n_acc   = 0;
  int  rdy_mode = 0;
  int  cyc = 0;
  tw_t prev;
  bit  prev_stall = 1'b0;

  axis_byte_packer dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_tready (i_tready),
    .i_tvalid (i_tvalid),
    .i_tdata  (i_tdata),
    .i_tlast  (i_tlast),
    .o_tready (o_tready),
    .o_tvalid (o_tvalid),
    .o_tdata  (o_tdata),
    .o_tlast  (o_tlast),
    .o_tkeep  (o_tkeep)
`ifdef AXIS_PACKER_STAT_EN
    ,
    .o_pkt_len(o_pkt_len),
    .o_pkt_cnt(o_pkt_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Sink ready: 0 = always ready, 1 = random 50%, otherwise stalled.
  initial begin
    o_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       o_tready = 1'b1;
        1:       o_tready = 1'($urandom_range(0, 1));
        default: o_tready = 1'b0;
      endcase
    end
  end

  // Collects delivered words and checks output stability while stalled.
  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_tests++;
        if (!o_tvalid || {o_tdata, o_tkeep, o_tlast} !== prev) begin
          n_fail++;
          $display("FAIL stable: got v=%b %h/%h/%b want v=1 %h/%h/%b",
                   o_tvalid, o_tdata, o_tkeep, o_tlast, prev.data, prev.keep, prev.last);
        end
      end
      if (o_tvalid && o_tready) rx_q.push_back({o_tdata, o_tkeep, o_tlast});
      prev_stall = o_tvalid && !o_tready;
      prev       = {o_tdata, o_tkeep, o_tlast};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Reference: chop the packet into groups of four, little-endian, tkeep from group size.
  task automatic model_pkt(input byte_q_t pkt);
    int n = pkt.size();
    for (int i = 0; i < n; i += 4) begin
      tw_t w;
      int  m = (n - i < 4) ? n - i : 4;
      w = '0;
      for (int j = 0; j < m; j++) w.data[8*j +: 8] = pkt[i+j];
      w.keep = 4'((1 << m) - 1);
      w.last = (i + m == n);
      exp_q.push_back(w);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int guard = 0;
    bit done  = 1'b0;
    i_tvalid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    i_tvalid = 1'b1;
    i_tdata  = b;
    i_tlast  = last;
    while (!done) begin
      @(negedge clk);
      if (i_tready) done = 1'b1;
      @(posedge clk);
      #1;
      guard++;
      if (!done && guard > 2000) begin
        n_tests++;
        n_fail++;
        $display("FAIL send_byte: got i_tready=0 for %0d cycles want 1", guard);
        done = 1'b1;
      end
    end
    i_tvalid = 1'b0;
    n_acc++;
  endtask

  task automatic send_pkt(input byte_q_t pkt, input bit rnd_gap);
    for (int i = 0; i < pkt.size(); i++)
      send_byte(pkt[i], i == pkt.size() - 1, rnd_gap ? int'($urandom_range(0, 1)) : 0);
  endtask

  task automatic check_stream(input string name);
    int guard = 0;
    int n;
    while (rx_q.size() < exp_q.size() && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    repeat (8) @(posedge clk);
    #1;
    n_tests++;
    if (rx_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s count: got %0d words want %0d", name, rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (rx_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s word %0d: got %h/%h/%b want %h/%h/%b", name, i,
                 rx_q[i].data, rx_q[i].keep, rx_q[i].last,
                 exp_q[i].data, exp_q[i].keep, exp_q[i].last);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    n_tests++;
    if (o_tvalid !== 1'b0 || o_tdata !== 32'h0 || o_tkeep !== 4'h0 ||
        o_tlast !== 1'b0 || i_tready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: got v=%b d=%h k=%h l=%b rdy=%b want v=0 d=0 k=0 l=0 rdy=1",
               name, o_tvalid, o_tdata, o_tkeep, o_tlast, i_tready);
    end
  endtask

  task automatic test_reset();
    rstn     = 1'b0;
    i_tvalid = 1'b1;
    i_tdata  = 8'h99;
    i_tlast  = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int c0;
    rdy_mode = 0;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), i == 8, 0);
      if (i == 4) begin
        n_tests++;
        if (o_tvalid !== 1'b1 || o_tdata !== 32'h04030201) begin
          n_fail++;
          $display("FAIL latency: got v=%b d=%h want v=1 d=04030201", o_tvalid, o_tdata);
        end
      end
    end
    n_tests++;
    if (cyc - c0 != 8) begin
      n_fail++;
      $display("FAIL throughput: got %0d cycles want 8", cyc - c0);
    end
    exp_q.push_back({32'h04030201, 4'hF, 1'b0});
    exp_q.push_back({32'h08070605, 4'hF, 1'b1});
    check_stream("basic");
  endtask

  task automatic test_short_packets();
    rdy_mode = 0;
    send_byte(8'hAA, 1'b1, 0);
    send_byte(8'hBB, 1'b0, 0);
    send_byte(8'hCC, 1'b1, 0);
    send_byte(8'hDD, 1'b0, 0);
    send_byte(8'hEE, 1'b0, 0);
    send_byte(8'hFF, 1'b1, 0);
    exp_q.push_back({32'h000000AA, 4'h1, 1'b1});
    exp_q.push_back({32'h0000CCBB, 4'h3, 1'b1});
    exp_q.push_back({32'h00FFEEDD, 4'h7, 1'b1});
    check_stream("short_pkts");
  endtask

  task automatic test_stall();
    byte_q_t pkt;
    rdy_mode = 0;
    n_acc = 0;
    for (int i = 0; i < 64; i++) pkt.push_back(8'($urandom));
    model_pkt(pkt);
    fork
      send_pkt(pkt, 1'b0);
      begin
        repeat (20) @(negedge clk);
        rdy_mode = 2;
        repeat (10) @(negedge clk);
        #1;
        n_tests++;
        if (i_tready !== 1'b0 || o_tvalid !== 1'b1 || (n_acc % 4) != 0 ||
            (n_acc / 4) - rx_q.size() != 2) begin
          n_fail++;
          $display("FAIL stall_fill: got rdy=%b v=%b acc=%0d rx=%0d want rdy=0 v=1 pending=2",
                   i_tready, o_tvalid, n_acc, rx_q.size());
        end
        rdy_mode = 0;
        @(negedge clk); #1;
        n_tests++;
        if (i_tready !== 1'b0) begin
          n_fail++;
          $display("FAIL stall_recover_early: got rdy=%b want 0", i_tready);
        end
        @(negedge clk); #1;
        n_tests++;
        if (i_tready !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_recover: got rdy=%b want 1", i_tready);
        end
      end
    join
    check_stream("stall_stream");
  endtask

  task automatic test_random();
    rdy_mode = 1;
    for (int p = 0; p < 1000; p++) begin
      byte_q_t pkt;
      int len = int'($urandom_range(1, 9));
      for (int i = 0; i < len; i++) pkt.push_back(8'($urandom));
      model_pkt(pkt);
      send_pkt(pkt, 1'b1);
    end
    check_stream("random");
    rdy_mode = 0;
  endtask

  task automatic test_mid_reset();
    byte_q_t pkt;
    rdy_mode = 2;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h60 + i), 1'b0, 0);
    n_tests++;
    if (o_tvalid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_valid: got v=%b want 1", o_tvalid);
    end
    i_tvalid = 1'b1;
    i_tdata  = 8'h5A;
    i_tlast  = 1'b1;
    rstn     = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    i_tvalid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rx_q.delete();
    exp_q.delete();
    rdy_mode = 0;
    @(posedge clk); #1;
    pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_pkt(pkt, 1'b0);
    exp_q.push_back({32'h44332211, 4'hF, 1'b1});
    check_stream("after_reset");
  endtask

`ifdef AXIS_PACKER_STAT_EN
  task automatic test_stats();
    byte_q_t p5;
    byte_q_t p3;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rdy_mode = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) p5.push_back(8'($urandom));
    for (int i = 0; i < 3; i++) p3.push_back(8'($urandom));
    model_pkt(p5);
    send_pkt(p5, 1'b1);
    n_tests++;
    if (o_pkt_len !== 32'd5 || o_pkt_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL stats_first: got len=%0d cnt=%0d want len=5 cnt=1", o_pkt_len, o_pkt_cnt);
    end
    model_pkt(p3);
    send_pkt(p3, 1'b1);
    n_tests++;
    if (o_pkt_len !== 32'd3 || o_pkt_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL stats_second: got len=%0d cnt=%0d want len=3 cnt=2", o_pkt_len, o_pkt_cnt);
    end
    check_stream("stats_stream");
  endtask
`endif

  initial begin
    i_tvalid = 1'b0;
    i_tdata  = 8'h00;
    i_tlast  = 1'b0;
    test_reset();
    test_basic();
    test_short_packets();
    test_stall();
    test_random();
    test_mid_reset();
`ifdef AXIS_PACKER_STAT_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
